// File: rtl/counter_updn_cfg.sv
// counter_updn_cfg: parametrised up/down event counter with selectable
// boundary policy (0 = sticky halt, 1 = wrap, 2 = saturate), synchronous
// clear/load, sticky overflow/underflow flags and a registered boundary pulse.
module counter_updn_cfg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MODE  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             act,
    input  logic             up_dwn_n,
    output logic [WIDTH-1:0] count,
    output logic             ovflw,
    output logic             undflw,
    output logic             bnd_evt,
    output logic             halted,
    output logic             busy
);

    localparam int unsigned STATE_W = 4;
    localparam int unsigned S_IDLE  = 0;
    localparam int unsigned S_CNTUP = 1;
    localparam int unsigned S_CNTDN = 2;
    localparam int unsigned S_HALT  = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = STATE_W'(1) << S_IDLE;
    localparam logic [STATE_W-1:0] ST_CNTUP = STATE_W'(1) << S_CNTUP;
    localparam logic [STATE_W-1:0] ST_CNTDN = STATE_W'(1) << S_CNTDN;
    localparam logic [STATE_W-1:0] ST_HALT  = STATE_W'(1) << S_HALT;

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [WIDTH-1:0]   count_d;
    logic               ovflw_d;
    logic               undflw_d;
    logic               bnd_evt_d;

    logic state_ok;
    logic at_max;
    logic at_zero;
    logic bnd_step;

    // Boundary detection and one-hot legality of the current state.
    always_comb begin
        state_ok = $onehot(state_q);
        at_max   = (count == '1);
        at_zero  = (count == '0);
        bnd_step = act && (up_dwn_n ? at_max : at_zero);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: clr/load and illegal encodings return to IDLE, HALT is sticky.
    always_comb begin
        state_d = state_q;
        if (clr || load || !state_ok) begin
            state_d = ST_IDLE;
        end else if (state_q[S_HALT]) begin
            state_d = ST_HALT;
        end else if (!act) begin
            state_d = ST_IDLE;
        end else if (bnd_step && (MODE == 0)) begin
            state_d = ST_HALT;
        end else if (up_dwn_n) begin
            state_d = ST_CNTUP;
        end else begin
            state_d = ST_CNTDN;
        end
    end

    // Next values of the count, sticky flags and boundary pulse.
    always_comb begin
        count_d   = count;
        ovflw_d   = ovflw;
        undflw_d  = undflw;
        bnd_evt_d = 1'b0;
        if (clr) begin
            count_d  = '0;
            ovflw_d  = 1'b0;
            undflw_d = 1'b0;
        end else if (load) begin
            count_d  = load_val;
            ovflw_d  = 1'b0;
            undflw_d = 1'b0;
        end else if (!state_ok || state_q[S_HALT] || !act) begin
            count_d = count;
        end else if (bnd_step) begin
            bnd_evt_d = 1'b1;
            if (up_dwn_n) begin
                ovflw_d = 1'b1;
            end else begin
                undflw_d = 1'b1;
            end
            // Only the wrap policy moves past the boundary; natural modulo arithmetic does it.
            if (MODE == 1) begin
                count_d = up_dwn_n ? (count + CNT_ONE) : (count - CNT_ONE);
            end
        end else begin
            count_d = up_dwn_n ? (count + CNT_ONE) : (count - CNT_ONE);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            ovflw   <= 1'b0;
            undflw  <= 1'b0;
            bnd_evt <= 1'b0;
        end else begin
            count   <= count_d;
            ovflw   <= ovflw_d;
            undflw  <= undflw_d;
            bnd_evt <= bnd_evt_d;
        end
    end

    // Status decoded straight from the state flops.
    assign halted = state_q[S_HALT];
    assign busy   = state_q[S_CNTUP] | state_q[S_CNTDN];

endmodule
